// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the MIPS register file and the write-back path that feeds it.
// Holds architectural register indices, default widths and the destination/source selects.
package regfile_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Destination register select driven by decode into write-back.
  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } dst_sel_e;

  // Write-back data source select; the write-back mux uses the same encodings.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC8  = 2'd2,
    WB_HILO = 2'd3
  } wb_src_e;

  function automatic logic [4:0] dst_index(input dst_sel_e sel,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
    logic [4:0] idx;
    idx = REG_ZERO;
    case (sel)
      DST_RT:  idx = rt;
      DST_RD:  idx = rd;
      DST_RA:  idx = REG_RA;
      default: idx = REG_ZERO;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/regfile_wb_scoreboard.sv
// Per-register pending-write scoreboard: issue sets a bit, write-back clears it.
// Busy lookups are masked when the retiring write is bypassed in the same cycle.
module regfile_wb_scoreboard
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2,
  output logic              any_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit BYP   = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] sb_q;
  logic [DEPTH-1:0] sb_d;
  logic             set_en;
  logic             clr_en;
  logic             wb_clr1;
  logic             wb_clr2;

  assign set_en = iss_valid && (iss_rd != ZERO_IDX);
  assign clr_en = we && (waddr != ZERO_IDX);

  // Clear first, then set, so a new producer supersedes the retiring one.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[waddr] = 1'b0;
    if (set_en) sb_d[iss_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  assign wb_clr1 = we && (waddr == raddr1) && !(iss_valid && (iss_rd == raddr1));
  assign wb_clr2 = we && (waddr == raddr2) && !(iss_valid && (iss_rd == raddr2));

  assign busy1    = sb_q[raddr1] && !(BYP && wb_clr1);
  assign busy2    = sb_q[raddr2] && !(BYP && wb_clr2);
  assign any_busy = |sb_q[DEPTH-1:1];

endmodule

// File: rtl/regfile_wb.sv
// 32x32 MIPS register file with two combinational read ports, optional write bypass
// and a pending-write scoreboard for issue stalls. Register 0 reads as zero.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busy1,
  output logic              busy2,
  output logic              any_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit BYP   = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;

  assign wr_en = we && (waddr != ZERO_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Index 0 is checked before the bypass so a discarded write never leaks through.
  always_comb begin
    rdata1 = mem_q[raddr1];
    if (raddr1 == ZERO_IDX)                 rdata1 = '0;
    else if (BYP && wr_en && waddr == raddr1) rdata1 = wdata;
  end

  always_comb begin
    rdata2 = mem_q[raddr2];
    if (raddr2 == ZERO_IDX)                 rdata2 = '0;
    else if (BYP && wr_en && waddr == raddr2) rdata2 = wdata;
  end

  regfile_wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .busy1     (busy1),
    .busy2     (busy2),
    .any_busy  (any_busy)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: bypassing and non-bypassing instances share one stimulus
// stream and are checked against an array/bitmap reference model.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        iss_valid;
  logic [4:0]  iss_rd;

  logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
  logic        busy1_b, busy2_b, any_busy_b;
  logic        busy1_n, busy2_n, any_busy_n;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  bit          m_sb   [32];

  always #5 clk = ~clk;

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy1(busy1_b), .busy2(busy2_b), .any_busy(any_busy_b)
  );

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n), .rdata2(rdata2_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy1(busy1_n), .busy2(busy2_n), .any_busy(any_busy_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit bp, input logic [4:0] ra);
    if (ra == 0) return 32'h0;
    if (bp && we && waddr == ra) return wdata;
    return m_regs[ra];
  endfunction

  function automatic logic exp_busy(input bit bp, input logic [4:0] ra);
    bit retiring;
    if (ra == 0) return 1'b0;
    retiring = we && (waddr == ra) && !(iss_valid && iss_rd == ra);
    return m_sb[ra] && !(bp && retiring);
  endfunction

  function automatic logic exp_any();
    for (int i = 1; i < 32; i++) if (m_sb[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_sb[i]   = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".b.rdata1"}, rdata1_b, exp_rd(1'b1, raddr1));
    chk({tag, ".b.rdata2"}, rdata2_b, exp_rd(1'b1, raddr2));
    chk({tag, ".b.busy1"}, 32'(busy1_b), 32'(exp_busy(1'b1, raddr1)));
    chk({tag, ".b.busy2"}, 32'(busy2_b), 32'(exp_busy(1'b1, raddr2)));
    chk({tag, ".b.any"}, 32'(any_busy_b), 32'(exp_any()));
    chk({tag, ".n.rdata1"}, rdata1_n, exp_rd(1'b0, raddr1));
    chk({tag, ".n.rdata2"}, rdata2_n, exp_rd(1'b0, raddr2));
    chk({tag, ".n.busy1"}, 32'(busy1_n), 32'(exp_busy(1'b0, raddr1)));
    chk({tag, ".n.busy2"}, 32'(busy2_n), 32'(exp_busy(1'b0, raddr2)));
    chk({tag, ".n.any"}, 32'(any_busy_n), 32'(exp_any()));
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic step(input string tag, input bit w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                      input bit iv, input logic [4:0] ir);
    we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
    iss_valid = iv; iss_rd = ir;
    #1;
    check_all(tag);
    @(posedge clk);
    if (we && waddr != 0) m_regs[waddr] = wdata;
    if (we && waddr != 0) m_sb[waddr] = 1'b0;
    if (iss_valid && iss_rd != 0) m_sb[iss_rd] = 1'b1;
    #1;
  endtask

  task automatic idle_read(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    step(tag, 1'b0, 5'd0, 32'h0, r1, r2, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd31;
    iss_valid = 1'b0; iss_rd = '0;
    model_reset();
    #2;
    check_all("reset_hold");
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("after_reset");

    // Async reset mid-cycle clears storage and scoreboard immediately.
    step("rst_wr5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 5'd20);
    idle_read("rst_rd5", 5'd5, 5'd20);
    chk("rst_pre_data", rdata1_b, 32'hDEADBEEF);
    chk("rst_pre_any", 32'(any_busy_b), 32'd1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_rdata1", rdata1_b, 32'h0);
    chk("rst_async_any", 32'(any_busy_b), 32'd0);
    chk("rst_async_busy2", 32'(busy2_b), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain write then read on both ports; index 0 discards writes.
    step("wr7", 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 1'b0, 5'd0);
    idle_read("rd7", 5'd7, 5'd7);
    chk("rd7_p1", rdata1_b, 32'h12345678);
    chk("rd7_p2", rdata2_n, 32'h12345678);
    step("wr0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("wr0_bypass_zero", rdata1_b, 32'h0);
    idle_read("rd0", 5'd0, 5'd0);
    chk("rd0_zero", rdata1_b, 32'h0);

    // Bypass: same-cycle read of the register being written.
    step("wr9_init", 1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 1'b0, 5'd0);
    step("wr9_byp", 1'b1, 5'd9, 32'hABCD, 5'd0, 5'd9, 1'b0, 5'd0);
    idle_read("rd9", 5'd9, 5'd9);
    chk("rd9_b", rdata2_b, 32'hABCD);
    chk("rd9_n", rdata2_n, 32'hABCD);

    // Scoreboard set by issue, cleared by write-back with same-cycle busy override.
    step("iss12", 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 1'b1, 5'd12);
    idle_read("busy12", 5'd12, 5'd12);
    chk("busy12_b", 32'(busy1_b), 32'd1);
    chk("busy12_any", 32'(any_busy_b), 32'd1);
    step("clr12", 1'b1, 5'd12, 32'h55AA55AA, 5'd12, 5'd12, 1'b0, 5'd0);
    idle_read("after_clr12", 5'd12, 5'd0);
    chk("after_clr12_any", 32'(any_busy_b), 32'd0);

    // Set and clear of the same index in one cycle: set wins, data still written.
    step("iss4", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4);
    step("setclr4", 1'b1, 5'd4, 32'hCAFE0004, 5'd4, 5'd4, 1'b1, 5'd4);
    idle_read("after_setclr4", 5'd4, 5'd4);
    chk("setclr4_busy", 32'(busy1_b), 32'd1);
    chk("setclr4_data", rdata1_b, 32'hCAFE0004);
    step("clr4", 1'b1, 5'd4, 32'h4, 5'd0, 5'd0, 1'b0, 5'd0);

    // Issue to register 0 never marks anything busy.
    step("iss0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
    idle_read("after_iss0", 5'd0, 5'd0);
    chk("iss0_any", 32'(any_busy_b), 32'd0);

    // Random traffic biased toward a few registers so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, r1, r2, ir;
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ir = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 2) == 0) ? ir : 5'($urandom_range(0, 31));
      step("rand", 1'($urandom_range(0, 1)), wa, $urandom, r1, r2,
           ($urandom_range(0, 9) < 4), ir);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
